// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} mult_state_t;

  // Bit counter width; a 1-bit floor keeps tiny WIDTH values legal.
  function automatic int cntWidth(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/add_sub_unit.sv
// Combinational WIDTH+1-bit adder/subtractor feeding the accumulator register A.
module add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] S,
  input  logic             sub,
  input  logic             sign_ext,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] aExt;
  logic [WIDTH:0] sExt;

  // One guard bit keeps the signed -2^(W-1) corner and the unsigned carry exact.
  always_comb begin
    aExt = {sign_ext & A[WIDTH-1], A};
    sExt = {sign_ext & S[WIDTH-1], S};
    sum  = sub ? (aExt - sExt) : (aExt + sExt);
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: S times register B, product left in {A,B}.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t     state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;
  logic [CW-1:0]    cnt_q;
  logic             signed_q;
  logic             busy_q;
  logic             done_q;
  logic             subOp;
  logic [WIDTH:0]   sum;

  // The multiplier's sign bit carries negative weight, so the last step subtracts.
  assign subOp = signed_q && (cnt_q == LAST);

  add_sub_unit #(.WIDTH(WIDTH)) u_add_sub (
    .A        (a_q),
    .S        (S),
    .sub      (subOp),
    .sign_ext (signed_q),
    .sum      (sum)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= 1'b0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!Run) begin
            a_q      <= '0;
            x_q      <= 1'b0;
            cnt_q    <= '0;
            signed_q <= Signed;
            busy_q   <= 1'b1;
            state_q  <= ADD;
          end else if (!ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= S;
          end
        end
        ADD: begin
          if (b_q[0]) begin
            a_q <= sum[WIDTH-1:0];
            x_q <= sum[WIDTH];
          end
          state_q <= SHIFT;
        end
        SHIFT: begin
          // X acts as the sign in signed mode but is a one-shot carry in unsigned mode.
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          x_q   <= signed_q ? x_q : 1'b0;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= HOLD;
          end else begin
            state_q <= ADD;
          end
        end
        HOLD: begin
          if (Run) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Parametrised sequential shift-add multiplier for the switch/hex lab processor. It multiplies the operand on the switch bus `S` by the multiplier held in register B and leaves the 2·WIDTH-bit product in A:B. Signed mode handles two's-complement operands; unsigned mode handles unsigned operands. B keeps the low half of the result, so repeated Run presses chain multiplications. The block sits between the debounced/synchronised button and switch inputs and the hex display drivers, which stay outside it.

## Interface
- `WIDTH`, default 8: operand width (≥2). The product is {Aval, Bval}, 2·WIDTH bits.
- `Clk`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Run`  in  1  active-low start. Synchronous level, already debounced.
- `ClearA_LoadB`  in  1  active-low. In IDLE: A←0, X←0, B←S.
- `Signed`  in  1  1 = two's-complement mode, 0 = unsigned. Latched at start.
- `S`  in  WIDTH  multiplicand / load value.
- `Aval`  out  WIDTH  upper product half (register A).
- `Bval`  out  WIDTH  lower product half / multiplier (register B).
- `X`  out  1  extension bit: sign in signed mode, carry in unsigned mode.
- `Busy`  out  1  high while a multiply is in progress.
- `Done`  out  1  high in HOLD: result valid, waiting for Run release.

## Operation
- Reset (Reset=0, any state, including mid-multiply): A, B, X, count ← 0; state ← IDLE; Busy=0, Done=0. This takes effect immediately, without waiting for a clock edge.
- States:
  - IDLE
    - Run=0 → A←0, X←0, count←0, latch `Signed` → ADD.
    - Else, ClearA_LoadB=0 → A←0, X←0, B←S.
    - Run has priority when both are low.
  - ADD
    - If B[0]=1: A ← sum[WIDTH-1:0], X ← sum[WIDTH]. Otherwise A and X hold.
    - Sum uses a WIDTH+1-bit adder.
      - Signed mode: sign-extend A and S.
      - Unsigned mode: zero-extend A and S.
    - Operation is A−S only when signed mode and count=WIDTH−1 (multiplier sign bit). Otherwise A+S.
    - → SHIFT.
  - SHIFT
    - {X,A,B} ← {X, X, A, B[WIDTH-1:1]}: X moves into A's MSB.
    - Signed mode: X is retained. Unsigned mode: X ← 0 after the shift.
    - count ← count+1. If count=WIDTH−1 → HOLD, else → ADD.
  - HOLD: Done=1. Run=1 → IDLE. ClearA_LoadB is ignored.
- ClearA_LoadB and changes on S are ignored in ADD, SHIFT and HOLD. S must stay stable from the start edge until HOLD.
- Chaining: the next Run computes S × Bval and discards the old A. The result is the low-half truncation of the running product.
- Busy=1 exactly in ADD and SHIFT.
- Product is exact for all operands in both modes, including −2^(WIDTH−1) × −2^(WIDTH−1) in signed mode.

## Timing
- Edge E0 samples Run=0 in IDLE. Busy rises after E0.
- Per multiplier bit: 2 cycles (ADD, SHIFT). Total 2·WIDTH cycles in the multiply.
- Done rises after edge E0+2·WIDTH. For WIDTH=8 that is 17 edges after Run is first sampled low. Aval, Bval and X are final at the same moment.
- Run must be high for one edge in HOLD to return to IDLE. A new multiply needs Run low again in IDLE, so there is one multiply per press.
- The ClearA_LoadB load is visible one edge after it is sampled low.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package `mult_pkg`: state enum `mult_state_t` {IDLE, ADD, SHIFT, HOLD}, and the count-width function $clog2(WIDTH).
- Sub-module `add_sub_unit #(WIDTH)`: combinational WIDTH+1-bit adder/subtractor.
  - Inputs: A, S, sub, sign_ext.
  - Output: sum[WIDTH:0].
- Everything else (FSM, A/B/X registers, counter) lives in `seq_mult_ctrl`.

## Test plan
- WIDTH=8, signed: load B=7, S=59, Run → after 17 edges Done=1, {Aval,Bval}=0x019D, X=0.
- WIDTH=8, signed, all sign combinations:
  - 7×−59 and −7×59 → 0xFE63, X=1.
  - −7×−59 → 0x019D.
- Chaining: load B=−2, then four Run presses with S=−2 → final {Aval,Bval}=0xFFE0 (−32).
- WIDTH=8, unsigned: 255×255 → 0xFE01, X=0. Same operands in signed mode → 0x0001.
- WIDTH=16, signed: 1000×−3 → {Aval,Bval}=0xFFFFF448. −32768×−32768 → 0x40000000.
- Robustness, each case separately:
  - Pulse Reset low during SHIFT → all outputs 0, state IDLE at once.
  - ClearA_LoadB low during Busy → no effect on the product.
  - Run held low → exactly one multiply, Done stays high.
